// File: rtl/tacc_uni.sv
// Temporal accumulator: sums the unary product streams of a series of multiplier terms
// into a saturating OWIDTH-bit result, one term per load/stop window.
module tacc_uni #(
    parameter int CWIDTH = 8,
    parameter int NTERM  = 16,
    parameter int OWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iStart,
    input  logic              iLoad,
    input  logic              iLast,
    input  logic              iC,
    input  logic              iStop,
    output logic [OWIDTH-1:0] oSum,
    output logic              oValid,
    output logic              oBusy,
    output logic              oOvf,
    output logic              oErr
);

    localparam int TWIDTH = $clog2(NTERM + 1);
    localparam logic [OWIDTH-1:0] ACC_MAX    = '1;
    localparam logic [CWIDTH-1:0] RUN_MAX    = '1;
    localparam logic [TWIDTH-1:0] TERM_LIMIT = TWIDTH'(NTERM);

    typedef enum logic [2:0] {IDLE, ARMED, SKIP, COUNT, DONE} state_t;

    state_t            state;
    logic [OWIDTH-1:0] acc;
    logic [TWIDTH-1:0] terms;
    logic [CWIDTH-1:0] run_len;
    logic              last_q;
    logic [OWIDTH:0]   acc_sum;
    logic [TWIDTH-1:0] terms_next;

    // The extra top bit of acc_sum is the carry that signals saturation.
    assign acc_sum    = {1'b0, acc} + {{OWIDTH{1'b0}}, iC};
    assign terms_next = terms + TWIDTH'(1);
    assign oBusy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            terms   <= '0;
            run_len <= '0;
            last_q  <= 1'b0;
            oSum    <= '0;
            oValid  <= 1'b0;
            oOvf    <= 1'b0;
            oErr    <= 1'b0;
        end else begin
            oValid <= 1'b0;
            // iStart restarts from any state and takes priority over a coincident iLoad.
            if (iStart) begin
                acc     <= '0;
                terms   <= '0;
                run_len <= '0;
                last_q  <= 1'b0;
                oOvf    <= 1'b0;
                oErr    <= 1'b0;
                state   <= ARMED;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    ARMED: begin
                        if (iLoad) begin
                            last_q  <= iLast;
                            run_len <= '0;
                            state   <= SKIP;
                        end
                    end
                    SKIP: begin
                        if (iLoad) oErr <= 1'b1;
                        state <= COUNT;
                    end
                    COUNT: begin
                        if (iLoad) oErr <= 1'b1;
                        if (!iStop) begin
                            if (acc_sum[OWIDTH]) begin
                                acc  <= ACC_MAX;
                                oOvf <= 1'b1;
                            end else begin
                                acc <= acc_sum[OWIDTH-1:0];
                            end
                            // A window longer than the longest legal stream is a protocol error.
                            if (run_len == RUN_MAX) oErr <= 1'b1;
                            else                    run_len <= run_len + CWIDTH'(1);
                        end else begin
                            terms <= terms_next;
                            if (last_q || (terms_next == TERM_LIMIT)) begin
                                oSum   <= acc;
                                oValid <= 1'b1;
                                state  <= DONE;
                            end else begin
                                state <= ARMED;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tacc_uni.sv
// Directed bench for tacc_uni: one task per scenario, each with hand-computed expectations.
module tb_tacc_uni;

    logic        clk = 1'b0;
    logic        rst_n, iStart, iLoad, iLast, iC, iStop;
    logic [11:0] sum;
    logic        valid, busy, ovf, err;
    logic [7:0]  sum8;
    logic        valid8, busy8, ovf8, err8;

    int total = 0;
    int bad = 0;
    int valid_count = 0;

    tacc_uni dut (
        .clk(clk), .rst_n(rst_n), .iStart(iStart), .iLoad(iLoad), .iLast(iLast),
        .iC(iC), .iStop(iStop), .oSum(sum), .oValid(valid), .oBusy(busy),
        .oOvf(ovf), .oErr(err)
    );

    // Narrow-accumulator copy fed by the same stimulus, used for the saturation case.
    tacc_uni #(.CWIDTH(8), .NTERM(16), .OWIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .iStart(iStart), .iLoad(iLoad), .iLast(iLast),
        .iC(iC), .iStop(iStop), .oSum(sum8), .oValid(valid8), .oBusy(busy8),
        .oOvf(ovf8), .oErr(err8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid === 1'b1) valid_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    // One term: load, the ignored skip cycle, len active cycles with ones of them high, then stop.
    task automatic run_term(input logic last, input int len, input int ones);
        iStop = 1'b1;
        iLoad = 1'b1;
        iLast = last;
        tick();
        iLoad = 1'b0;
        iLast = 1'b0;
        iC    = 1'b1;
        tick();
        for (int i = 0; i < len; i++) begin
            iStop = 1'b0;
            iC    = (i < ones);
            tick();
        end
        iStop = 1'b1;
        iC    = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iStart = 1'b0; iLoad = 1'b0; iLast = 1'b0; iC = 1'b0; iStop = 1'b1;
        tick();
        tick();
        total++; if (sum !== 12'd0) begin bad++; $display("[TB] FAIL reset_sum got=%0d want=0", sum); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", ovf); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err); end
        rst_n = 1'b1;
        tick();
        iLoad = 1'b1;
        tick();
        iLoad = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_load_busy got=%b want=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL idle_load_err got=%b want=0", err); end
    endtask

    task automatic test_single();
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_armed_busy got=%b want=1", busy); end
        run_term(1'b1, 200, 77);
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", valid); end
        total++; if (sum !== 12'd77) begin bad++; $display("[TB] FAIL single_sum got=%0d want=77", sum); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_after got=%b want=0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_after got=%b want=0", valid); end
        total++; if (sum !== 12'd77) begin bad++; $display("[TB] FAIL single_sum_hold got=%0d want=77", sum); end
    endtask

    task automatic test_zero();
        pulse_start();
        iStop = 1'b1;
        iLoad = 1'b1;
        iLast = 1'b1;
        tick();
        iLoad = 1'b0;
        iLast = 1'b0;
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL zero_valid_c1 got=%b want=0", valid); end
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL zero_valid_c2 got=%b want=0", valid); end
        tick();
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL zero_valid_c3 got=%b want=1", valid); end
        total++; if (sum !== 12'd0) begin bad++; $display("[TB] FAIL zero_sum got=%0d want=0", sum); end
        tick();
    endtask

    task automatic test_three();
        int vc;
        pulse_start();
        vc = valid_count;
        run_term(1'b0, 30, 10);
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL three_mid_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL three_mid_busy got=%b want=1", busy); end
        run_term(1'b0, 5, 0);
        run_term(1'b1, 255, 255);
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL three_valid got=%b want=1", valid); end
        total++; if (sum !== 12'd265) begin bad++; $display("[TB] FAIL three_sum got=%0d want=265", sum); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL three_ovf got=%b want=0", ovf); end
        tick();
        tick();
        total++; if (valid_count - vc !== 1) begin bad++; $display("[TB] FAIL three_pulses got=%0d want=1", valid_count - vc); end
    endtask

    task automatic test_sixteen();
        pulse_start();
        for (int k = 0; k < 15; k++) run_term(1'b0, 255, 255);
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL sixteen_t15_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL sixteen_t15_busy got=%b want=1", busy); end
        run_term(1'b0, 255, 255);
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL sixteen_valid got=%b want=1", valid); end
        total++; if (sum !== 12'd4080) begin bad++; $display("[TB] FAIL sixteen_sum got=%0d want=4080", sum); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL sixteen_ovf got=%b want=0", ovf); end
        tick();
    endtask

    task automatic test_saturate();
        pulse_start();
        run_term(1'b0, 200, 200);
        run_term(1'b1, 200, 200);
        total++; if (sum8 !== 8'd255) begin bad++; $display("[TB] FAIL sat_sum8 got=%0d want=255", sum8); end
        total++; if (ovf8 !== 1'b1) begin bad++; $display("[TB] FAIL sat_ovf8 got=%b want=1", ovf8); end
        total++; if (sum !== 12'd400) begin bad++; $display("[TB] FAIL sat_wide_sum got=%0d want=400", sum); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL sat_wide_ovf got=%b want=0", ovf); end
        tick();
        total++; if (ovf8 !== 1'b1) begin bad++; $display("[TB] FAIL sat_ovf8_sticky got=%b want=1", ovf8); end
        pulse_start();
        total++; if (ovf8 !== 1'b0) begin bad++; $display("[TB] FAIL sat_ovf8_clear got=%b want=0", ovf8); end
    endtask

    task automatic test_error();
        pulse_start();
        iLoad = 1'b1;
        iLast = 1'b1;
        tick();
        iLoad = 1'b0;
        iLast = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            iStop = 1'b0;
            iC    = (i < 12);
            iLoad = (i == 5);
            tick();
        end
        iLoad = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_set got=%b want=1", err); end
        iStop = 1'b1;
        iC    = 1'b0;
        tick();
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL err_valid got=%b want=1", valid); end
        total++; if (sum !== 12'd12) begin bad++; $display("[TB] FAIL err_sum got=%0d want=12", sum); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky got=%b want=1", err); end
        tick();
    endtask

    task automatic test_back_to_back();
        pulse_start();
        iLoad = 1'b1;
        iLast = 1'b1;
        tick();
        iLoad = 1'b0;
        iLast = 1'b0;
        tick();
        iStop = 1'b0;
        iC    = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        iLoad = 1'b1;
        tick();
        iLoad = 1'b0;
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL restart_err_pre got=%b want=1", err); end
        // Restart mid-term with a coincident load that must be ignored.
        iStart = 1'b1;
        iLoad  = 1'b1;
        tick();
        iStart = 1'b0;
        iLoad  = 1'b0;
        iStop  = 1'b1;
        iC     = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL restart_busy got=%b want=1", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL restart_err got=%b want=0", err); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL restart_valid got=%b want=0", valid); end
        total++; if (sum !== 12'd12) begin bad++; $display("[TB] FAIL restart_sum_kept got=%0d want=12", sum); end
        run_term(1'b1, 10, 3);
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL restart_new_valid got=%b want=1", valid); end
        total++; if (sum !== 12'd3) begin bad++; $display("[TB] FAIL restart_new_sum got=%0d want=3", sum); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL restart_new_err got=%b want=0", err); end
        tick();
    endtask

    task automatic test_midreset();
        int vc;
        pulse_start();
        iLoad = 1'b1;
        iLast = 1'b1;
        tick();
        iLoad = 1'b0;
        iLast = 1'b0;
        tick();
        iStop = 1'b0;
        iC    = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        iLoad = 1'b1;
        tick();
        iLoad = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        iStop = 1'b1;
        iC    = 1'b0;
        total++; if (sum !== 12'd0) begin bad++; $display("[TB] FAIL mrst_sum got=%0d want=0", sum); end
        total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_valid got=%b want=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mrst_busy got=%b want=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL mrst_err got=%b want=0", err); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL mrst_ovf got=%b want=0", ovf); end
        vc = valid_count;
        tick();
        tick();
        tick();
        total++; if (valid_count !== vc) begin bad++; $display("[TB] FAIL mrst_no_pulse got=%0d want=%0d", valid_count, vc); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mrst_stays_idle got=%b want=0", busy); end
        pulse_start();
        run_term(1'b1, 9, 5);
        total++; if (valid !== 1'b1) begin bad++; $display("[TB] FAIL mrst_after_valid got=%b want=1", valid); end
        total++; if (sum !== 12'd5) begin bad++; $display("[TB] FAIL mrst_after_sum got=%0d want=5", sum); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero();
        test_three();
        test_sixteen();
        test_saturate();
        test_error();
        test_back_to_back();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tacc_uni.md
TACC_UNI -- requirements
Module: tacc_uni

Interface
REQ-001 Parameter CWIDTH, default 8: maximum temporal-stream length per product term is 2^CWIDTH-1 cycles.
REQ-002 Parameter NTERM, default 16: maximum number of product terms per accumulation.
REQ-003 Parameter OWIDTH, default 12: width of the accumulated sum.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 iStart  input  1  one-cycle pulse that clears the accumulator and begins a new accumulation.
REQ-007 iLoad  input  1  one-cycle pulse that is cycle-aligned with the multiplier's loadA and marks the start of a product term.
REQ-008 iLast  input  1  sampled with iLoad; 1 marks that term as the final term.
REQ-009 iC  input  1  unary product bitstream from the multiplier.
REQ-010 iStop  input  1  multiplier stop flag; 0 means the stream window is active.
REQ-011 oSum  output  OWIDTH  registered result; holds until the next completion or reset.
REQ-012 oValid  output  1  one-cycle pulse that is coincident with a new oSum.
REQ-013 oBusy  output  1  1 in every state except IDLE.
REQ-014 oOvf  output  1  sticky saturation flag for the current accumulation.
REQ-015 oErr  output  1  sticky protocol-error flag for the current accumulation.

Function
REQ-016 The FSM shall have exactly the states IDLE, ARMED, SKIP, COUNT and DONE.
REQ-017 IDLE: on iStart, clear acc, term counter, oOvf and oErr; go to ARMED.
REQ-018 ARMED: on iLoad, capture iLast into last_q; go to SKIP. No accumulation occurs in ARMED.
REQ-019 SKIP: lasts exactly one cycle and covers the registered-stop latency after a load; iC and iStop are ignored; go to COUNT.
REQ-020 COUNT, iStop=0: acc <= acc + iC; remain in COUNT.
REQ-021 COUNT, iStop=1: the term ends and no add occurs; increment the term counter; go to DONE if last_q=1 or the term counter reaches NTERM, otherwise go to ARMED.
REQ-022 If the first COUNT cycle has iStop=1, the term contributes 0 (zero operand); this shall not hang the FSM.
REQ-023 DONE (one cycle): oSum <= acc (saturated), oValid=1; go to IDLE.
REQ-024 Addition shall saturate at 2^OWIDTH-1; any saturating add sets oOvf, and oOvf stays set until the next iStart or reset.
REQ-025 iLoad in SKIP or COUNT shall set oErr and is otherwise ignored; the current term continues.
REQ-026 iStart in any non-IDLE state shall restart the accumulation: acc, term counter, oOvf and oErr are cleared; the state goes to ARMED; oSum is unchanged.
REQ-027 When iStart and iLoad occur in the same cycle, iStart wins and iLoad is ignored.
REQ-028 iLoad in IDLE shall be ignored and shall not set oErr.
REQ-029 oValid shall be 0 in every state except DONE.
REQ-030 The term counter shall be wide enough to hold NTERM; the accumulator shall be OWIDTH bits.
REQ-031 With default parameters (16 x 255 = 4080) saturation is unreachable; the saturation logic shall still be present.

Reset
REQ-032 While rst_n=0 at a clock edge: state=IDLE, acc=0, term counter=0, oSum=0, oValid=0, oBusy=0, oOvf=0, oErr=0.
REQ-033 Reset asserted mid-accumulation shall abandon the accumulation; no oValid pulse follows.
REQ-034 After reset, an accumulation starts only on iStart.

Verification
REQ-035 Single term: iStart, then iLoad with iLast=1; drive iStop low for 200 cycles with iC=1 on 77 of them, then iStop=1 -> oValid pulse with oSum=77, oBusy returns to 0 the following cycle.
REQ-036 Zero operand: iLoad with iLast=1 and iStop held at 1 -> term contributes 0, DONE is reached 3 cycles after iLoad, oSum=0.
REQ-037 Three terms contributing 10, 0 and 255, with iLast on the third -> oSum=265, oOvf=0, exactly one oValid pulse.
REQ-038 Sixteen terms of 255 each with iLast never asserted -> DONE after the 16th term, oSum=4080; with OWIDTH=8 and two terms of 200 -> oSum=255, oOvf=1.
REQ-039 iLoad pulsed in COUNT -> oErr=1 and the sum is unaffected; iStart during COUNT -> state ARMED, acc=0, oErr=0, previous oSum retained.
REQ-040 rst_n low for one cycle mid-COUNT -> all outputs at their reset values next cycle and no oValid pulse; a subsequent iStart works normally.
